mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers plus an IDLE/WAIT/DONE sequencer that
// runs fixed wait states followed by a bounded wait for the memory ready strobe.
module mem_access_unit #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] MAR_out,
  output logic [WIDTH-1:0]  MDR_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] WS_INIT = 8'(WAIT_STATES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic              err_q, err_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [WIDTH-1:0]  mdr_q, mdr_d;
  logic              ld_ok_s;

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= 8'd0;
      tcnt_q  <= 8'd0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Next-state, counters and register loads.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ld_ok_s = (state_q != S_WAIT);

    // Host loads are frozen while an access is in flight; a coincident start sees the new values.
    if (ld_ok_s && LD_MAR) begin
      mar_d = bus_in[ADDR_W-1:0];
    end else begin
      mar_d = mar_q;
    end
    if (ld_ok_s && LD_MDR) begin
      mdr_d = MIO_EN ? mem_rdata : bus_in;
    end else begin
      mdr_d = mdr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_rd || start_wr) begin
          state_d = S_WAIT;
          op_wr_d = ~start_rd;
          wcnt_d  = WS_INIT;
          tcnt_d  = 8'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_q != 8'd0) begin
          wcnt_d = wcnt_q - 8'd1;
        end else if (mem_ready) begin
          if (!op_wr_q) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          state_d = S_DONE;
          err_d   = 1'b0;
        end else if (tcnt_q == TO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          tcnt_d  = tcnt_q + 8'd1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  assign MAR_out   = mar_q;
  assign MDR_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_ce    = (state_q == S_WAIT);
  assign mem_we    = (state_q == S_WAIT) && op_wr_q;
  assign busy      = (state_q == S_WAIT);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver predicts each
// access outcome from timing rules and a separate monitor checks every done pulse.
module tb_mem_access_unit;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 16;
  localparam int WS     = 2;
  localparam int TO     = 8;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [WIDTH-1:0]  bus_in = '0;
  logic              LD_MAR = 1'b0, LD_MDR = 1'b0, MIO_EN = 1'b0;
  logic              start_rd = 1'b0, start_wr = 1'b0;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] MAR_out, mem_addr;
  logic [WIDTH-1:0]  MDR_out, mem_wdata;
  logic              mem_ce, mem_we, busy, done, err;

  mem_access_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .bus_in(bus_in), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .MIO_EN(MIO_EN), .start_rd(start_rd), .start_wr(start_wr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .MAR_out(MAR_out), .MDR_out(MDR_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ce(mem_ce), .mem_we(mem_we), .busy(busy), .done(done),
    .err(err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int                done_cyc;
    logic              err;
    logic [WIDTH-1:0]  mdr;
    logic [ADDR_W-1:0] mar;
    int                ce_n;
    int                we_n;
    logic [WIDTH-1:0]  wdata;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  // Reference register contents as the host sees them.
  logic [ADDR_W-1:0] mar_m = '0;
  logic [WIDTH-1:0]  mdr_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rand_loads(input bit apply);
    LD_MAR = 1'($urandom_range(0, 1));
    LD_MDR = 1'($urandom_range(0, 1));
    MIO_EN = 1'($urandom_range(0, 1));
    bus_in = WIDTH'($urandom);
    if (apply) begin
      if (LD_MAR) mar_m = bus_in[ADDR_W-1:0];
      if (LD_MDR) mdr_m = MIO_EN ? mem_rdata : bus_in;
    end
  endtask

  // One access with random surrounding host activity; entered and left in IDLE.
  task automatic run_txn();
    int nidle, s, r, i, op, dcnt;
    bit never, wr;
    exp_t e;
    nidle = $urandom_range(0, 2);
    for (int k = 0; k < nidle; k++) begin
      mem_rdata = WIDTH'($urandom);
      rand_loads(1'b1);
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
    end
    mem_rdata = WIDTH'($urandom);
    rand_loads(1'b1);
    op = $urandom_range(0, 2);
    start_rd  = (op != 1);
    start_wr  = (op != 0);
    wr        = (op == 1);
    mem_ready = 1'b0;
    s     = cyc;
    never = ($urandom_range(0, 4) == 0);
    r     = $urandom_range(0, WS + TO + 1);
    i     = (r < WS) ? WS : r;
    e.mar   = mar_m;
    e.wdata = mdr_m;
    if (never || i >= WS + TO) begin
      e.err      = 1'b1;
      e.done_cyc = s + WS + TO + 1;
      e.ce_n     = WS + TO;
    end else begin
      e.err      = 1'b0;
      e.done_cyc = s + i + 2;
      e.ce_n     = i + 1;
      if (!wr) mdr_m = mem_rdata;
    end
    e.mdr  = mdr_m;
    e.we_n = wr ? e.ce_n : 0;
    sb_q.push_back(e);
    dcnt = 0;
    forever begin
      @(posedge Clk); #1;
      if (done) break;
      dcnt++;
      if (dcnt > 300) begin
        checks++;
        errors++;
        $display("FAIL done_wait_timeout: got no done after %0d cycles expected done", dcnt);
        break;
      end
      rand_loads(1'b0);
      start_rd  = 1'($urandom_range(0, 1));
      start_wr  = 1'($urandom_range(0, 1));
      mem_ready = !never && (cyc >= s + 1 + r);
    end
    // DONE cycle: loads land, starts are dropped.
    mem_ready = 1'b0;
    mem_rdata = WIDTH'($urandom);
    rand_loads(1'b1);
    start_rd = 1'($urandom_range(0, 1));
    start_wr = 1'($urandom_range(0, 1));
    @(posedge Clk); #1;
    start_rd = 1'b0;
    start_wr = 1'b0;
  endtask

  int ce_n = 0, we_n = 0;
  logic [ADDR_W-1:0] addr_c;
  logic [WIDTH-1:0]  wd_c;

  // Monitor: accumulates the strobe profile of each access and checks it on done.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      ce_n = 0;
      we_n = 0;
    end else begin
      if (mem_ce) begin
        if (ce_n == 0) begin
          addr_c = mem_addr;
          wd_c   = mem_wdata;
        end
        ce_n++;
        if (mem_we) we_n++;
      end else if (mem_we) begin
        chk("we_without_ce", 64'(mem_ce), 64'd1);
      end
      if (err && !done) chk("err_without_done", 64'(done), 64'd1);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("err", 64'(err), 64'(e.err));
          chk("MDR_out", 64'(MDR_out), 64'(e.mdr));
          chk("MAR_out", 64'(MAR_out), 64'(e.mar));
          chk("ce_cycles", 64'(ce_n), 64'(e.ce_n));
          chk("we_cycles", 64'(we_n), 64'(e.we_n));
          chk("access_addr", 64'(addr_c), 64'(e.mar));
          if (e.we_n > 0) chk("write_data", 64'(wd_c), 64'(e.wdata));
        end
        ce_n = 0;
        we_n = 0;
      end
    end
  end

  initial begin
    #2 Reset = 1'b1;
    #1;
    chk("rst_MAR", 64'(MAR_out), 64'd0);
    chk("rst_MDR", 64'(MDR_out), 64'd0);
    chk("rst_ce", 64'(mem_ce), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    for (int n = 0; n < 150; n++) run_txn();

    // Asynchronous reset in the middle of a read that would otherwise time out.
    LD_MAR = 1'b1;
    bus_in = 16'h3000;
    LD_MDR = 1'b1;
    MIO_EN = 1'b0;
    mem_ready = 1'b0;
    start_rd = 1'b1;
    start_wr = 1'b0;
    @(posedge Clk); #1;
    LD_MAR = 1'b0;
    LD_MDR = 1'b0;
    start_rd = 1'b0;
    @(posedge Clk); #1;
    chk("pre_rst_ce", 64'(mem_ce), 64'd1);
    chk("pre_rst_addr", 64'(mem_addr), 64'h3000);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_ce", 64'(mem_ce), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_MAR", 64'(MAR_out), 64'd0);
    chk("mid_rst_MDR", 64'(MDR_out), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    mar_m = '0;
    mdr_m = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    for (int n = 0; n < 40; n++) run_txn();

    repeat (3) @(posedge Clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
